// File: rtl/param_fault_mem.sv
// Word-addressed memory with a single injectable fault cell and a 2-cycle read pipeline.
// Optional macro FAULT_MEM_FAULT_CNT_EN compiles in the fault activation counter.
module param_fault_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CAPACITY   = 16,
  parameter int FAULT_ADDR = 5,
  parameter int FAULT_BIT  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_read,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [2:0]            fault_type,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic [7:0]            fault_cnt
);

  localparam logic [ADDR_WIDTH:0]   CAP_L    = (ADDR_WIDTH+1)'(CAPACITY);
  localparam logic [ADDR_WIDTH-1:0] VICTIM_L = ADDR_WIDTH'(FAULT_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ABOVE_L  = ADDR_WIDTH'(FAULT_ADDR + 1);
  localparam logic [ADDR_WIDTH-1:0] BELOW_L  = ADDR_WIDTH'(FAULT_ADDR - 1);

  localparam logic [2:0] FT_SA0  = 3'd1;
  localparam logic [2:0] FT_SA1  = 3'd2;
  localparam logic [2:0] FT_TFUP = 3'd3;
  localparam logic [2:0] FT_TFDN = 3'd4;
  localparam logic [2:0] FT_NPSF = 3'd5;

  logic                  s0_valid_r;
  logic                  s0_wr_r;
  logic [ADDR_WIDTH-1:0] s0_addr_r;
  logic [DATA_WIDTH-1:0] s0_wdata_r;
  logic [2:0]            s0_ft_r;
  logic                  s1_rd_r;
  logic [DATA_WIDTH-1:0] s1_rdata_r;
  logic [DATA_WIDTH-1:0] mem_r [CAPACITY];

  logic                  in_range_s;
  logic                  is_victim_s;
  logic [DATA_WIDTH-1:0] old_word_s;
  logic                  old_bit_s;
  logic                  req_bit_s;
  logic                  npsf_s;
  logic                  wr_bit_s;
  logic                  rd_bit_s;
  logic [DATA_WIDTH-1:0] wr_word_s;
  logic [DATA_WIDTH-1:0] rd_word_s;

  // Stage-1 datapath: fault-model the victim bit of the word being accessed.
  always_comb begin
    in_range_s  = ({1'b0, s0_addr_r} < CAP_L);
    is_victim_s = in_range_s && (s0_addr_r == VICTIM_L);
    if (in_range_s) begin
      old_word_s = mem_r[s0_addr_r];
    end else begin
      old_word_s = {DATA_WIDTH{1'b0}};
    end
    old_bit_s = old_word_s[FAULT_BIT];
    req_bit_s = s0_wdata_r[FAULT_BIT];
    // Neighbourhood pattern that freezes the victim bit
    npsf_s = mem_r[ABOVE_L][FAULT_BIT] & mem_r[BELOW_L][FAULT_BIT] &
             ~mem_r[VICTIM_L][FAULT_BIT+1] & ~mem_r[VICTIM_L][FAULT_BIT-1];
    case (s0_ft_r)
      FT_SA0:  begin wr_bit_s = 1'b0; rd_bit_s = 1'b0; end
      FT_SA1:  begin wr_bit_s = 1'b1; rd_bit_s = 1'b1; end
      FT_TFUP: begin wr_bit_s = (~old_bit_s & req_bit_s) ? 1'b0 : req_bit_s; rd_bit_s = old_bit_s; end
      FT_TFDN: begin wr_bit_s = (old_bit_s & ~req_bit_s) ? 1'b1 : req_bit_s; rd_bit_s = old_bit_s; end
      FT_NPSF: begin wr_bit_s = npsf_s ? old_bit_s : req_bit_s; rd_bit_s = old_bit_s; end
      default: begin wr_bit_s = req_bit_s; rd_bit_s = old_bit_s; end
    endcase
    wr_word_s = s0_wdata_r;
    rd_word_s = old_word_s;
    if (is_victim_s) begin
      wr_word_s[FAULT_BIT] = wr_bit_s;
      rd_word_s[FAULT_BIT] = rd_bit_s;
    end else begin
      wr_word_s = s0_wdata_r;
      rd_word_s = old_word_s;
    end
  end

  // Stage-0 request capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid_r <= 1'b0;
      s0_wr_r    <= 1'b0;
      s0_addr_r  <= {ADDR_WIDTH{1'b0}};
      s0_wdata_r <= {DATA_WIDTH{1'b0}};
      s0_ft_r    <= 3'd0;
    end else begin
      s0_valid_r <= 1'b1;
      s0_wr_r    <= write_read;
      s0_addr_r  <= address;
      s0_wdata_r <= wdata;
      s0_ft_r    <= fault_type;
    end
  end

  // Array commit; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CAPACITY; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (s0_valid_r && s0_wr_r && in_range_s) begin
      mem_r[s0_addr_r] <= wr_word_s;
    end
  end

  // Stage-1 read capture and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_rd_r     <= 1'b0;
      s1_rdata_r  <= {DATA_WIDTH{1'b0}};
      rdata       <= {DATA_WIDTH{1'b0}};
      rdata_valid <= 1'b0;
    end else begin
      s1_rd_r     <= s0_valid_r & ~s0_wr_r;
      if (s0_valid_r && !s0_wr_r) begin
        s1_rdata_r <= rd_word_s;
      end
      rdata_valid <= s1_rd_r;
      if (s1_rd_r) begin
        rdata <= s1_rdata_r;
      end
    end
  end

`ifdef FAULT_MEM_FAULT_CNT_EN
  logic golden_r;
  logic act_s;

  // A victim access whose result departs from the fault-free bit is an activation.
  always_comb begin
    act_s = 1'b0;
    if (s0_valid_r && is_victim_s) begin
      act_s = s0_wr_r ? (wr_bit_s != req_bit_s) : (rd_bit_s != golden_r);
    end else begin
      act_s = 1'b0;
    end
  end

  // Fault-free shadow of the victim bit and the saturating activation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      golden_r  <= 1'b0;
      fault_cnt <= 8'd0;
    end else begin
      if (s0_valid_r && s0_wr_r && is_victim_s) begin
        golden_r <= req_bit_s;
      end
      if (act_s && (fault_cnt != 8'hFF)) begin
        fault_cnt <= fault_cnt + 8'd1;
      end
    end
  end
`else
  // Counter compiled out.
  always_ff @(posedge clk) begin
    fault_cnt <= 8'd0;
  end
`endif

endmodule

// File: doc/param_fault_mem.md
PARAM_FAULT_MEM -- requirements
Module: param_fault_mem

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, address width in bits.
REQ-003 SHALL have parameter CAPACITY, default 16, number of words; addresses 0..CAPACITY-1 valid.
REQ-004 SHALL have parameter FAULT_ADDR, default 5, victim word address; legal range 1..CAPACITY-2.
REQ-005 SHALL have parameter FAULT_BIT, default 5, victim bit index; legal range 1..DATA_WIDTH-2.
REQ-006 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-007 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-008 SHALL have port write_read  input  1  1 = write request, 0 = read request, every cycle.
REQ-009 SHALL have port address  input  ADDR_WIDTH  request address.
REQ-010 SHALL have port wdata  input  DATA_WIDTH  write data, same cycle as address.
REQ-011 SHALL have port fault_type  input  3  active fault model, sampled with each request.
REQ-012 SHALL have port rdata  output  DATA_WIDTH  registered read data.
REQ-013 SHALL have port rdata_valid  output  1  high for one cycle when rdata holds a read result.
REQ-014 SHALL have port fault_cnt  output  8  count of fault activations.

Function
REQ-015 SHALL register write_read, address, wdata, fault_type at edge N (stage 0); array write or array read occurs at edge N+1; rdata and rdata_valid update at edge N+2 (read latency 2).
REQ-016 SHALL make a write committed at edge N+1 visible to a read issued in the next cycle (no read-after-write hazard).
REQ-017 SHALL drive rdata_valid=1 at edge N+2 only for read requests; rdata holds its last value otherwise.
REQ-018 SHALL ignore requests whose address >= CAPACITY: no array change; reads return all-zero with rdata_valid=1.
REQ-019 SHALL apply fault_type only to bit FAULT_BIT of word FAULT_ADDR; all other cells are fault-free.
REQ-020 fault_type 0: no fault; 6 and 7: reserved, treated as 0.
REQ-021 fault_type 1 (SA0): victim bit stored as 0 on write and returned as 0 on read.
REQ-022 fault_type 2 (SA1): victim bit stored as 1 on write and returned as 1 on read.
REQ-023 fault_type 3 (TF-up): a write requesting victim 0->1 leaves it 0; other transitions normal.
REQ-024 fault_type 4 (TF-down): a write requesting victim 1->0 leaves it 1; other transitions normal.
REQ-025 fault_type 5 (NPSF): when word FAULT_ADDR+1 bit FAULT_BIT=1, word FAULT_ADDR-1 bit FAULT_BIT=1, victim word bit FAULT_BIT+1=0 and bit FAULT_BIT-1=0 (current array values), a write to FAULT_ADDR keeps the old victim bit; otherwise normal write.
REQ-026 SHALL count an activation when a write or read result differs from the fault-free value at the victim bit; fault_cnt increments by 1 at the commit edge and saturates at 255.

Reset
REQ-027 SHALL, with rst=1 at an edge, clear all pipeline registers, rdata, rdata_valid and fault_cnt to 0 and all array words to 0.
REQ-028 SHALL discard any in-flight request when rst asserts mid-operation; no array write from it after reset.
REQ-029 SHALL accept the first request on the first edge with rst=0.

Configuration
REQ-030 Macro FAULT_MEM_FAULT_CNT_EN defined: fault_cnt counter per REQ-026 compiled in.
REQ-031 Macro FAULT_MEM_FAULT_CNT_EN undefined: no counter logic; fault_cnt tied to 0; all other behaviour identical.

Verification
REQ-032 Reset, write 0xA5 to addr 3, read addr 3 -> rdata=0xA5, rdata_valid pulse 2 cycles after read request.
REQ-033 fault_type=1, write 0xFF to addr 5 then read -> rdata=0xDF, fault_cnt=2 (write and read activations, macro defined).
REQ-034 fault_type=3, write 0x00 then 0x20 to addr 5, read -> rdata=0x00; fault_type=4, write 0x20 then 0x00, read -> rdata=0x20.
REQ-035 fault_type=5, write 0x20 to addr 4 and 6, 0x00 to addr 5, then 0x20 to addr 5, read -> rdata=0x00; repeat with addr 6=0x00 -> rdata=0x20.
REQ-036 Assert rst while a read to addr 5 is in flight -> rdata=0, rdata_valid=0, fault_cnt=0, subsequent read of any address returns 0x00.
REQ-037 Build without FAULT_MEM_FAULT_CNT_EN, run REQ-033 stimulus -> rdata=0xDF, fault_cnt=0.
